// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light lamp-bus safety monitor.
// Lamp encodings, tracked phases, fault codes and phase helper functions.
package tlc_pkg;

    localparam logic [1:0] GREEN   = 2'b11;
    localparam logic [1:0] YELLOW  = 2'b10;
    localparam logic [1:0] RED     = 2'b00;
    localparam logic [1:0] ILLEGAL = 2'b01;

    typedef enum logic [2:0] {
        P_SYNC        = 3'd0,
        P_ALLRED_A    = 3'd1,
        P_HWY_GREEN   = 3'd2,
        P_HWY_YELLOW  = 3'd3,
        P_ALLRED_B    = 3'd4,
        P_FARM_GREEN  = 3'd5,
        P_FARM_YELLOW = 3'd6,
        P_FAULT       = 3'd7
    } phase_t;

    typedef enum logic [2:0] {
        F_NONE     = 3'd0,
        F_CONFLICT = 3'd1,
        F_ILLEGAL  = 3'd2,
        F_SEQUENCE = 3'd3,
        F_SHORT    = 3'd4,
        F_STUCK    = 3'd5
    } fault_t;

    // Lamp pair {highway, farm} that a phase expects on the buses.
    function automatic logic [3:0] phase_pair(input phase_t p);
        logic [3:0] r;
        case (p)
            P_HWY_GREEN:   r = {GREEN, RED};
            P_HWY_YELLOW:  r = {YELLOW, RED};
            P_FARM_GREEN:  r = {RED, GREEN};
            P_FARM_YELLOW: r = {RED, YELLOW};
            default:       r = {RED, RED};
        endcase
        return r;
    endfunction

    // Only legal next phase of the normal cycle.
    function automatic phase_t phase_succ(input phase_t p);
        phase_t r;
        case (p)
            P_ALLRED_A:    r = P_HWY_GREEN;
            P_HWY_GREEN:   r = P_HWY_YELLOW;
            P_HWY_YELLOW:  r = P_ALLRED_B;
            P_ALLRED_B:    r = P_FARM_GREEN;
            P_FARM_GREEN:  r = P_FARM_YELLOW;
            P_FARM_YELLOW: r = P_ALLRED_A;
            default:       r = p;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tlc_sec_timer.sv
// Seconds counter: prescaler of TICKS_1S cycles feeding a saturating counter.
// Ports: i_clk, i_rst_n (async low), i_clr (sync clear), i_freeze (hold), o_sec.
module tlc_sec_timer #(
    parameter int TICKS_1S = 50000000,
    parameter int WIDTH    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_freeze,
    output logic [WIDTH-1:0] o_sec
);

    localparam int PW = (TICKS_1S > 1) ? $clog2(TICKS_1S) : 1;

    logic [PW-1:0]    r_presc;
    logic [WIDTH-1:0] r_sec;
    logic             w_wrap;

    assign w_wrap = (r_presc == PW'(TICKS_1S - 1));
    assign o_sec  = r_sec;

    // Clear wins over freeze so a clear on fault entry yields zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= '0;
            r_sec   <= '0;
        end else if (i_clr) begin
            r_presc <= '0;
            r_sec   <= '0;
        end else if (!i_freeze) begin
            r_presc <= w_wrap ? '0 : r_presc + 1'b1;
            if (w_wrap && (r_sec != {WIDTH{1'b1}})) begin
                r_sec <= r_sec + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlc_signal_monitor.sv
// Safety monitor for the lamp-drive buses: phase tracking, dwell timing, sticky fault.
// Ports: Clk, Rst (async low), highwaySignal, farmSignal, clrFault -> fault, faultCode, phase, dwellSec.
module tlc_signal_monitor
    import tlc_pkg::*;
#(
    parameter int TICKS_1S         = 50000000,
    parameter int MIN_HWY_GREEN_S  = 30,
    parameter int MIN_FARM_GREEN_S = 15,
    parameter int MIN_YELLOW_S     = 3,
    parameter int MIN_ALLRED_S     = 1,
    parameter int MAX_DWELL_S      = 60
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] highwaySignal,
    input  logic [1:0] farmSignal,
    input  logic       clrFault,
    output logic       fault,
    output logic [2:0] faultCode,
    output logic [2:0] phase,
    output logic [7:0] dwellSec
);

    logic [1:0] r_hw_q;
    logic [1:0] r_farm_q;
    phase_t     r_phase;
    logic       r_fault;
    logic [2:0] r_code;

    phase_t     w_phase_nxt;
    phase_t     w_eff;
    fault_t     w_det;
    logic       w_fault_nxt;
    logic [2:0] w_code_nxt;
    logic       w_clr;
    logic [3:0] w_pair;
    logic [7:0] w_sec;
    logic [7:0] w_dwell;
    logic       w_tmr_clr;
    logic       w_tmr_freeze;

    function automatic logic [7:0] min_dwell(input phase_t p);
        logic [7:0] r;
        case (p)
            P_HWY_GREEN:   r = 8'(MIN_HWY_GREEN_S);
            P_FARM_GREEN:  r = 8'(MIN_FARM_GREEN_S);
            P_HWY_YELLOW,
            P_FARM_YELLOW: r = 8'(MIN_YELLOW_S);
            P_ALLRED_A,
            P_ALLRED_B:    r = 8'(MIN_ALLRED_S);
            default:       r = 8'd0;
        endcase
        return r;
    endfunction

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_hw_q   <= RED;
            r_farm_q <= RED;
        end else begin
            r_hw_q   <= highwaySignal;
            r_farm_q <= farmSignal;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_phase <= P_SYNC;
            r_fault <= 1'b0;
            r_code  <= F_NONE;
        end else begin
            r_phase <= w_phase_nxt;
            r_fault <= w_fault_nxt;
            r_code  <= w_code_nxt;
        end
    end

    // A clear is applied first: checks then run as if already in SYNC
    // with zero dwell, so a fault present during the clear relatches.
    assign w_clr   = (r_phase == P_FAULT) && clrFault;
    assign w_pair  = {r_hw_q, r_farm_q};
    assign w_dwell = w_clr ? 8'd0 : w_sec;

    always_comb begin
        w_phase_nxt = r_phase;
        w_fault_nxt = r_fault;
        w_code_nxt  = r_code;
        w_det       = F_NONE;
        w_eff       = w_clr ? P_SYNC : r_phase;
        if (w_clr) begin
            w_phase_nxt = P_SYNC;
            w_fault_nxt = 1'b0;
            w_code_nxt  = F_NONE;
        end
        if (w_eff != P_FAULT) begin
            if ((r_hw_q != RED) && (r_farm_q != RED)) begin
                w_det = F_CONFLICT;
            end else if ((r_hw_q == ILLEGAL) || (r_farm_q == ILLEGAL)) begin
                w_det = F_ILLEGAL;
            end else if (w_eff == P_SYNC) begin
                if (w_pair == phase_pair(P_HWY_GREEN)) begin
                    w_phase_nxt = P_HWY_GREEN;
                end else if (w_pair == phase_pair(P_FARM_GREEN)) begin
                    w_phase_nxt = P_FARM_GREEN;
                end
            end else if (w_pair == phase_pair(w_eff)) begin
                if (w_dwell >= 8'(MAX_DWELL_S)) begin
                    w_det = F_STUCK;
                end
            end else if (w_pair != phase_pair(phase_succ(w_eff))) begin
                w_det = F_SEQUENCE;
            end else if (w_dwell < min_dwell(w_eff)) begin
                w_det = F_SHORT;
            end else if (w_dwell >= 8'(MAX_DWELL_S)) begin
                w_det = F_STUCK;
            end else begin
                w_phase_nxt = phase_succ(w_eff);
            end
            if (w_det != F_NONE) begin
                w_phase_nxt = P_FAULT;
                w_fault_nxt = 1'b1;
                w_code_nxt  = w_det;
            end
        end
    end

    // Dwell restarts on every real phase change and freezes once faulted.
    assign w_tmr_freeze = (w_phase_nxt == P_FAULT);
    assign w_tmr_clr    = w_clr ||
                          ((w_phase_nxt != r_phase) && !w_tmr_freeze);

    tlc_sec_timer #(
        .TICKS_1S (TICKS_1S),
        .WIDTH    (8)
    ) u_timer (
        .i_clk    (Clk),
        .i_rst_n  (Rst),
        .i_clr    (w_tmr_clr),
        .i_freeze (w_tmr_freeze),
        .o_sec    (w_sec)
    );

    assign fault     = r_fault;
    assign faultCode = r_code;
    assign phase     = r_phase;
    assign dwellSec  = w_sec;

endmodule

// File: tb/tb_tlc_signal_monitor.sv
// Self-checking bench for tlc_signal_monitor with a cycle-count reference model.
// Directed scenarios plus randomized phase walks, outputs compared every cycle.
module tb_tlc_signal_monitor;

    localparam int T = 4;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [1:0] highwaySignal;
    logic [1:0] farmSignal;
    logic       clrFault;
    logic       fault;
    logic [2:0] faultCode;
    logic [2:0] phase;
    logic [7:0] dwellSec;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Reference model state: registered inputs, phase, cycles since entry.
    int m_hwq, m_fq, m_phase, m_cyc, m_fault, m_code;

    // Per-phase tables indexed by phase number.
    int hw_of[8]  = '{0, 0, 3, 2, 0, 0, 0, 0};
    int fm_of[8]  = '{0, 0, 0, 0, 0, 3, 2, 0};
    int succ[8]   = '{0, 2, 3, 4, 5, 6, 1, 7};
    int min_s[8]  = '{0, 1, 30, 3, 1, 15, 3, 0};

    int seq_h[6]  = '{3, 2, 0, 0, 0, 0};
    int seq_f[6]  = '{0, 0, 0, 3, 2, 0};
    int seq_n[6]  = '{121, 13, 5, 61, 13, 5};

    always #5 Clk = ~Clk;

    tlc_signal_monitor #(.TICKS_1S(T)) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .highwaySignal (highwaySignal),
        .farmSignal    (farmSignal),
        .clrFault      (clrFault),
        .fault         (fault),
        .faultCode     (faultCode),
        .phase         (phase),
        .dwellSec      (dwellSec)
    );

    function automatic int dwell_of(input int c);
        return (c / T > 255) ? 255 : c / T;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_hwq = 0; m_fq = 0; m_phase = 0; m_cyc = 0; m_fault = 0; m_code = 0;
    endtask

    task automatic model_step(input int h, input int f, input int c);
        int ph, cy, d, code, nxt;
        bit cleared;
        ph = m_phase;
        cy = m_cyc;
        cleared = 1'b0;
        if (ph == 7 && c != 0) begin
            ph = 0; cy = 0; m_fault = 0; m_code = 0; cleared = 1'b1;
        end
        code = 0;
        nxt  = ph;
        if (ph != 7) begin
            d = dwell_of(cy);
            if (m_hwq != 0 && m_fq != 0) code = 1;
            else if (m_hwq == 1 || m_fq == 1) code = 2;
            else if (ph == 0) begin
                if (m_hwq == 3 && m_fq == 0) nxt = 2;
                else if (m_hwq == 0 && m_fq == 3) nxt = 5;
            end else if (m_hwq == hw_of[ph] && m_fq == fm_of[ph]) begin
                if (d >= 60) code = 5;
            end else if (m_hwq == hw_of[succ[ph]] && m_fq == fm_of[succ[ph]]) begin
                if (d < min_s[ph]) code = 4;
                else if (d >= 60) code = 5;
                else nxt = succ[ph];
            end else code = 3;
        end
        if (code != 0) begin
            m_fault = 1; m_code = code; m_phase = 7; m_cyc = cy;
        end else if (nxt != ph || cleared) begin
            m_phase = nxt; m_cyc = 0;
        end else begin
            m_phase = ph; m_cyc = (ph == 7) ? cy : cy + 1;
        end
        m_hwq = h;
        m_fq  = f;
    endtask

    task automatic step(input int h, input int f, input bit c);
        highwaySignal = 2'(h);
        farmSignal    = 2'(f);
        clrFault      = c;
        @(posedge Clk);
        model_step(h, f, int'(c));
        @(negedge Clk);
    endtask

    task automatic hold(input int h, input int f, input int n);
        repeat (n) step(h, f, 1'b0);
    endtask

    always @(negedge Clk) begin
        if (cmp_en && Rst) begin
            check("fault", int'(fault), m_fault);
            check("faultCode", int'(faultCode), m_code);
            check("phase", int'(phase), m_phase);
            check("dwellSec", int'(dwellSec), dwell_of(m_cyc));
        end
    end

    int r, n, k;

    initial begin
        Rst = 1'b0;
        highwaySignal = 2'b00;
        farmSignal = 2'b00;
        clrFault = 1'b0;
        model_reset();
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        cmp_en = 1'b1;
        check("reset_fault", int'(fault), 0);
        check("reset_code", int'(faultCode), 0);
        check("reset_phase", int'(phase), 0);
        check("reset_dwell", int'(dwellSec), 0);

        // Full legal cycle
        hold(3, 0, 124);
        check("green_dwell30", int'(dwellSec), 30);
        check("green_phase", int'(phase), 2);
        hold(2, 0, 13);
        check("hy_phase", int'(phase), 3);
        hold(0, 0, 5);
        check("arb_phase", int'(phase), 4);
        hold(0, 3, 61);
        check("fg_phase", int'(phase), 5);
        hold(0, 2, 13);
        check("fy_phase", int'(phase), 6);
        hold(0, 0, 5);
        check("ara_phase", int'(phase), 1);
        hold(3, 0, 6);
        check("cycle_phase", int'(phase), 2);
        check("cycle_fault", int'(fault), 0);

        // Conflict, then clear while conflict persists (relatch)
        hold(3, 3, 2);
        check("conf_fault", int'(fault), 1);
        check("conf_code", int'(faultCode), 1);
        check("conf_phase", int'(phase), 7);
        step(3, 3, 1'b1);
        check("relatch_code", int'(faultCode), 1);
        check("relatch_dwell", int'(dwellSec), 0);
        hold(0, 0, 2);
        step(0, 0, 1'b1);
        check("clr_fault", int'(fault), 0);
        check("clr_phase", int'(phase), 0);

        // Short yellow
        hold(3, 0, 124);
        hold(2, 0, 8);
        hold(0, 0, 2);
        check("short_code", int'(faultCode), 4);
        step(0, 0, 1'b1);
        check("short_clr_fault", int'(fault), 0);
        check("short_clr_phase", int'(phase), 0);

        // Bad sequence
        hold(3, 0, 10);
        hold(0, 0, 2);
        check("seq_code", int'(faultCode), 3);
        step(0, 0, 1'b1);

        // Stuck and frozen dwell
        hold(0, 3, 250);
        check("stuck_code", int'(faultCode), 5);
        check("stuck_dwell", int'(dwellSec), 60);
        hold(0, 3, 10);
        check("stuck_frozen", int'(dwellSec), 60);
        hold(0, 0, 2);
        step(0, 0, 1'b1);

        // Illegal encoding in SYNC, then asynchronous reset mid-cycle
        hold(1, 0, 2);
        check("illegal_code", int'(faultCode), 2);
        #2;
        Rst = 1'b0;
        model_reset();
        #1;
        check("arst_fault", int'(fault), 0);
        check("arst_phase", int'(phase), 0);
        check("arst_code", int'(faultCode), 0);
        @(negedge Clk);
        Rst = 1'b1;

        // Dwell saturation while idling in SYNC
        hold(0, 0, 1030);
        check("sat_dwell", int'(dwellSec), 255);

        // Randomized walks around the legal cycle
        k = 0;
        repeat (80) begin
            r = int'($urandom_range(0, 19));
            if (m_fault != 0) begin
                hold(0, 0, 2);
                step(0, 0, 1'b1);
            end else if (r < 16) begin
                n = seq_n[k] + int'($urandom_range(0, 4)) - 2;
                hold(seq_h[k], seq_f[k], n);
                k = (k + 1) % 6;
            end else if (r < 19) begin
                hold(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(1, 4)));
            end else begin
                step(seq_h[k], seq_f[k], 1'b1);
            end
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
